// File: rtl/fetch_buffer_if.sv
// Handshake bundle between the PC generator, instruction memory and decode,
// as seen from the fetch buffer (master) and from its environment (slave).
interface fetch_buffer_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_pc;
    logic            i_pc_valid;
    logic            o_pc_ready;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ack;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_flush;
    logic            o_inst_valid;
    logic [XLEN-1:0] o_inst;
    logic [XLEN-1:0] o_inst_pc;
    logic            i_inst_ready;

    modport master (
        input  i_pc, i_pc_valid, i_imem_ack, i_imem_rdata, i_flush, i_inst_ready,
        output o_pc_ready, o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc
    );

    modport slave (
        output i_pc, i_pc_valid, i_imem_ack, i_imem_rdata, i_flush, i_inst_ready,
        input  o_pc_ready, o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one outstanding imem read per accepted PC, returned
// words queued with their PC in a DEPTH-entry FIFO; flush discards everything.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              reset,
    fetch_buffer_if.master    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e          state_q;
    logic            imem_req_q;
    logic [XLEN-1:0] imem_addr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic not_full_s;
    logic pc_ready_s;
    logic inst_valid_s;
    logic push_s;
    logic pop_s;

    // Flush overrides accept and pop within the cycle it is raised.
    assign not_full_s   = (count_q < CW'(DEPTH));
    assign pc_ready_s   = !reset && (state_q == S_IDLE) && bus.i_pc_valid
                          && not_full_s && !bus.i_flush;
    assign inst_valid_s = (count_q != '0) && !bus.i_flush;
    assign push_s       = (state_q == S_WAIT) && bus.i_imem_ack && !bus.i_flush;
    assign pop_s        = inst_valid_s && bus.i_inst_ready;

    assign bus.o_pc_ready   = pc_ready_s;
    assign bus.o_imem_req   = imem_req_q;
    assign bus.o_imem_addr  = imem_addr_q;
    assign bus.o_inst_valid = inst_valid_s;
    assign bus.o_inst       = inst_mem[rd_ptr_q];
    assign bus.o_inst_pc    = pc_mem[rd_ptr_q];

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Request FSM; DROP keeps the request up so memory sees a clean completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pc_ready_s) begin
                        imem_addr_q <= bus.i_pc;
                        imem_req_q  <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (bus.i_flush) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bus.i_imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk) begin
        if (reset || bus.i_flush) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem[wr_ptr_q]   <= imem_addr_q;
            inst_mem[wr_ptr_q] <= bus.i_imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: stimulus pushes expected (pc, inst) pairs,
// a monitor pops and compares whenever decode consumes an entry.
module tb_fetch_buffer;
    logic clk;
    logic reset;

    fetch_buffer_if #(.XLEN(32)) bus ();

    fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] feed_q[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_inst[$];

    logic mem_auto;
    logic pop_on_ack;
    logic s_acc;
    logic s_inst_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic feed(input logic [31:0] pc);
        feed_q.push_back(pc);
    endtask

    task automatic fetch_exp(input logic [31:0] pc, input logic [31:0] inst);
        feed_q.push_back(pc);
        exp_pc.push_back(pc);
        exp_inst.push_back(inst);
    endtask

    // One clock: drive inputs after the edge, sample just before the next edge.
    task automatic tick();
        if (mem_auto) begin
            bus.i_imem_ack   = bus.o_imem_req;
            bus.i_imem_rdata = bus.o_imem_addr + 32'h1000_0000;
        end
        if (pop_on_ack) bus.i_inst_ready = bus.i_imem_ack;
        bus.i_pc_valid = (feed_q.size() != 0);
        bus.i_pc       = (feed_q.size() != 0) ? feed_q[0] : 32'h0;
        @(negedge clk);
        #3;
        s_acc        = bus.o_pc_ready;
        s_inst_valid = bus.o_inst_valid;
        if (bus.i_pc_valid && bus.o_pc_ready) void'(feed_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string name);
        int n = 0;
        while ((feed_q.size() != 0 || bus.o_imem_req === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(feed_q.size()) + 32'(bus.o_imem_req), 32'h0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.i_inst_ready = 1'b1;
        mem_auto = 1'b1;
        while ((exp_pc.size() != 0 || feed_q.size() != 0 || bus.o_imem_req === 1'b1) && n < 300) begin
            tick();
            n++;
        end
        tick();
        check(name, 32'(exp_pc.size()), 32'h0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [31:0] ep;
        logic [31:0] ei;
        forever begin
            @(negedge clk);
            #3;
            if (bus.o_inst_valid === 1'b1 && bus.i_inst_ready === 1'b1) begin
                vectors++;
                if (exp_pc.size() == 0) begin
                    miscompares++;
                    $display("FAIL mon_unexpected: got pc 0x%08h inst 0x%08h expected none",
                             bus.o_inst_pc, bus.o_inst);
                end else begin
                    ep = exp_pc.pop_front();
                    ei = exp_inst.pop_front();
                    if (bus.o_inst_pc !== ep || bus.o_inst !== ei) begin
                        miscompares++;
                        $display("FAIL mon_entry: got pc 0x%08h inst 0x%08h expected pc 0x%08h inst 0x%08h",
                                 bus.o_inst_pc, bus.o_inst, ep, ei);
                    end
                end
            end
        end
    end

    initial begin
        int acc_n;
        reset            = 1'b1;
        mem_auto         = 1'b0;
        pop_on_ack       = 1'b0;
        bus.i_imem_ack   = 1'b0;
        bus.i_imem_rdata = 32'h0;
        bus.i_flush      = 1'b0;
        bus.i_inst_ready = 1'b1;
        bus.i_pc_valid   = 1'b0;
        bus.i_pc         = 32'h0;

        // Test 1: reset state, latency and 1-per-2-cycle throughput
        fetch_exp(32'h0000_0000, 32'h1000_0000);
        fetch_exp(32'h0000_0004, 32'h1000_0004);
        fetch_exp(32'h0000_0008, 32'h1000_0008);
        tick();
        tick();
        check("rst_pc_ready", 32'(s_acc), 32'h0);
        check("rst_req", 32'(bus.o_imem_req), 32'h0);
        check("rst_addr", bus.o_imem_addr, 32'h0);
        check("rst_inst_valid", 32'(bus.o_inst_valid), 32'h0);
        reset    = 1'b0;
        mem_auto = 1'b1;
        tick();
        check("t1_accept0", 32'(s_acc), 32'h1);
        check("t1_req0", 32'(bus.o_imem_req), 32'h1);
        check("t1_addr0", bus.o_imem_addr, 32'h0);
        tick();
        check("t1_wait_ready", 32'(s_acc), 32'h0);
        check("t1_latency", 32'(bus.o_inst_valid), 32'h1);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check("t1_accept", 32'(s_acc), 32'h1);
            check("t1_addr", bus.o_imem_addr, 32'(4 * k));
            tick();
            check("t1_gap", 32'(s_acc), 32'h0);
        end
        drain("t1_drain");

        // Test 2: full FIFO back-pressures the PC generator
        bus.i_inst_ready = 1'b0;
        for (int k = 0; k < 6; k++) fetch_exp(32'h10 + 32'(4 * k), 32'h1000_0010 + 32'(4 * k));
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_acc) acc_n++;
        end
        check("t2_fill_accepts", 32'(acc_n), 32'h4);
        check("t2_head_pc", bus.o_inst_pc, 32'h0000_0010);
        check("t2_head_inst", bus.o_inst, 32'h1000_0010);
        bus.i_inst_ready = 1'b1;
        tick();
        bus.i_inst_ready = 1'b0;
        tick();
        check("t2_refill_accept", 32'(s_acc), 32'h1);
        check("t2_refill_addr", bus.o_imem_addr, 32'h0000_0020);
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_acc) acc_n++;
        end
        check("t2_full_again", 32'(acc_n), 32'h0);
        drain("t2_drain");

        // Test 3: flush in WAIT, ack three cycles later is dropped
        mem_auto         = 1'b0;
        bus.i_imem_ack   = 1'b0;
        bus.i_inst_ready = 1'b0;
        feed(32'h0000_0030);
        feed(32'h0000_0040);
        acc_n = 0;
        for (int i = 0; i < 5 && acc_n == 0; i++) begin
            tick();
            if (s_acc) acc_n++;
        end
        check("t3_first_accept", 32'(acc_n), 32'h1);
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = 32'h1000_0030;
        tick();
        bus.i_imem_ack = 1'b0;
        tick();
        check("t3_second_accept", 32'(s_acc), 32'h1);
        check("t3_queued", 32'(bus.o_inst_valid), 32'h1);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("t3_flush_valid", 32'(s_inst_valid), 32'h0);
        check("t3_drop_req", 32'(bus.o_imem_req), 32'h1);
        fetch_exp(32'h0000_0100, 32'h1000_0100);
        tick();
        check("t3_drop_ready1", 32'(s_acc), 32'h0);
        tick();
        check("t3_drop_ready2", 32'(s_acc), 32'h0);
        check("t3_drop_req2", 32'(bus.o_imem_req), 32'h1);
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = 32'hBAD0_0040;
        tick();
        bus.i_imem_ack = 1'b0;
        check("t3_ack_req", 32'(bus.o_imem_req), 32'h0);
        check("t3_not_queued", 32'(bus.o_inst_valid), 32'h0);
        drain("t3_drain");

        // Test 4: flush and ack together with two entries queued
        bus.i_inst_ready = 1'b0;
        feed(32'h0000_0050);
        feed(32'h0000_0054);
        feed(32'h0000_0058);
        acc_n = 0;
        for (int i = 0; i < 20 && acc_n < 3; i++) begin
            tick();
            if (s_acc) acc_n++;
        end
        mem_auto       = 1'b0;
        bus.i_imem_ack = 1'b0;
        check("t4_fill", 32'(acc_n), 32'h3);
        check("t4_head_pc", bus.o_inst_pc, 32'h0000_0050);
        bus.i_flush      = 1'b1;
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = 32'hBAD0_0058;
        tick();
        bus.i_flush    = 1'b0;
        bus.i_imem_ack = 1'b0;
        check("t4_flush_valid", 32'(s_inst_valid), 32'h0);
        check("t4_empty", 32'(bus.o_inst_valid), 32'h0);
        check("t4_req", 32'(bus.o_imem_req), 32'h0);
        fetch_exp(32'h0000_0200, 32'h1000_0200);
        tick();
        check("t4_ready_after", 32'(s_acc), 32'h1);
        drain("t4_drain");

        // Test 5: push+pop at count 2, pointer wrap over many entries
        bus.i_inst_ready = 1'b0;
        for (int k = 0; k < 2; k++) fetch_exp(32'h300 + 32'(4 * k), 32'h1000_0300 + 32'(4 * k));
        run_until_idle("t5_fill_idle");
        pop_on_ack = 1'b1;
        for (int k = 2; k < 12; k++) fetch_exp(32'h300 + 32'(4 * k), 32'h1000_0300 + 32'(4 * k));
        run_until_idle("t5_pairs_idle");
        pop_on_ack       = 1'b0;
        bus.i_inst_ready = 1'b0;
        for (int k = 12; k < 16; k++) fetch_exp(32'h300 + 32'(4 * k), 32'h1000_0300 + 32'(4 * k));
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_acc) acc_n++;
        end
        check("t5_count_held", 32'(acc_n), 32'h2);
        drain("t5_drain");

        // Test 6: reset in WAIT with three entries queued, late ack ignored
        bus.i_inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) feed(32'h400 + 32'(4 * k));
        acc_n = 0;
        for (int i = 0; i < 20 && acc_n < 4; i++) begin
            tick();
            if (s_acc) acc_n++;
        end
        mem_auto       = 1'b0;
        bus.i_imem_ack = 1'b0;
        check("t6_fill", 32'(acc_n), 32'h4);
        check("t6_head_pc", bus.o_inst_pc, 32'h0000_0400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_req", 32'(bus.o_imem_req), 32'h0);
        check("t6_rst_addr", bus.o_imem_addr, 32'h0);
        check("t6_rst_valid", 32'(bus.o_inst_valid), 32'h0);
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = 32'hDEAD_0000;
        tick();
        bus.i_imem_ack = 1'b0;
        check("t6_late_ack_valid", 32'(bus.o_inst_valid), 32'h0);
        check("t6_late_ack_req", 32'(bus.o_imem_req), 32'h0);
        fetch_exp(32'h0000_0500, 32'h1000_0500);
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
